ecc_scrub_ctrl: RTL and testbench
=================================

Name: ecc_scrub_ctrl

Overview:
- Controller that shares one single-port codeword memory (7-bit Hamming(7,4) words) between a host access port and a background scrubber.
- Encodes host writes and decodes/corrects host reads.
- Periodically walks the memory, writes back corrected codewords and counts corrected errors.
- Sits between the host bus logic and the ECC-protected RAM macro.

Parameters:
ADDR_W, 4, memory address width; depth = 2^ADDR_W words.
SCRUB_INTERVAL, 256, enabled cycles between scrub requests (>=2).
CNT_W, 8, width of the corrected-error counter.

Ports:
clk  input  1  clock; all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
host_req  input  1  access request; level, held until host_ack.
host_we  input  1  1 = write, 0 = read; stable while host_req is high.
host_addr  input  ADDR_W  access address; stable while host_req is high.
host_wdata  input  4  write data nibble.
host_ack  output  1  one-cycle completion pulse.
host_rdata  output  4  corrected read data; valid when host_ack is high after a read.
host_err  output  1  read needed a correction; valid with host_ack.
scrub_en  input  1  enables the scrub interval timer.
err_clr  input  1  synchronous clear of err_count.
mem_en  output  1  memory access strobe.
mem_we  output  1  memory write enable.
mem_addr  output  ADDR_W  memory address.
mem_wdata  output  7  codeword to memory.
mem_rdata  input  7  codeword from memory; valid the cycle after mem_en with mem_we=0.
err_count  output  CNT_W  saturating count of corrected errors.
busy  output  1  high when the FSM is not in IDLE.

Behaviour:
- Codeword map:
  - c[2]=d[0], c[4]=d[1], c[5]=d[2], c[6]=d[3].
  - c[0]=c2^c4^c6, c[1]=c2^c5^c6, c[3]=c4^c5^c6.
- Syndrome:
  - s0=c0^c2^c4^c6, s1=c1^c2^c5^c6, s2=c3^c4^c5^c6.
  - Nonzero s: flip bit c[s-1].
  - Data = {c6,c5,c4,c2} after correction.
- All outputs are registered. Reset value 0 for every output, for the scrub pointer, the interval counter and scrub_pending. FSM resets to IDLE.
- FSM states: IDLE, H_WR, H_RD, H_RDCHK, S_RD, S_CHK, S_WB.
- Arbitration, evaluated only in IDLE:
  - Only host_req high: go to host access.
  - Only scrub_pending high: go to S_RD.
  - Both high: alternate. Scrub wins if the last grant was host, otherwise host wins. last_grant resets to scrub, so host wins the first tie.
- Host write (request sampled in IDLE at edge k):
  - Cycle k+1 is H_WR: mem_en=1, mem_we=1, mem_wdata=encode(host_wdata), host_ack=1.
  - Then IDLE.
- Host read:
  - k+1 is H_RD: mem_en=1, mem_we=0.
  - k+2 is H_RDCHK: mem_rdata sampled and decoded.
  - k+3: host_ack=1, host_rdata and host_err valid, FSM back in IDLE.
  - host_err=1 iff syndrome is nonzero; err_count increments.
- Host must drop host_req the cycle after host_ack. A request still high in IDLE is a new access.
- Scrub timer:
  - Counts while scrub_en=1. At SCRUB_INTERVAL-1 it wraps to 0 and sets scrub_pending.
  - Pending does not accumulate.
  - scrub_en=0 clears the counter; an existing pending request is still serviced.
  - scrub_pending clears on entry to S_RD.
- Scrub sequence:
  - S_RD: read at scrub_ptr.
  - S_CHK: decode. Syndrome zero: IDLE. Nonzero: S_WB.
  - S_WB: write the corrected codeword to the same address, err_count increments, then IDLE.
  - scrub_ptr increments on leaving S_CHK or S_WB and wraps from 2^ADDR_W-1 to 0.
- err_count:
  - Saturates at all-ones.
  - err_clr has priority over a simultaneous increment.
- mem_en/mem_we are 0 in IDLE, H_RDCHK and S_CHK.
- busy=1 in every non-IDLE state.
- rst_n low mid-operation: all outputs drop to 0 immediately (asynchronous); no ack is issued for the aborted access.

Optional Feature:
- Macro: ECC_HOST_WRITEBACK_EN.
- Defined: a host read with a nonzero syndrome inserts state H_WB after H_RDCHK. H_WB writes the corrected codeword to host_addr; host_ack is issued in that same cycle (k+3), with the FSM returning to IDLE at k+4.
- Undefined: no host writeback; the error remains in memory until scrubbed.

Test Plan:
- Host write addr 2, data 4'b1011 -> one cycle with mem_en=1, mem_we=1, mem_addr=2, mem_wdata=7'b1010101, host_ack=1.
- Host read addr 2, memory returns 7'b1000101 (c4 flipped) -> host_ack at k+3, host_rdata=4'b1011, host_err=1, err_count=1. With ECC_HOST_WRITEBACK_EN, additionally a write of 7'b1010101 to addr 2.
- SCRUB_INTERVAL=8, scrub_en=1, addr 0 holds 7'b0000001 -> read of addr 0, then a write of 7'b0000000 to addr 0, err_count increments, scrub_ptr=1. Clean words cause reads only.
- host_req held continuously while scrub_pending is set -> grants alternate host, scrub, host. Scrub is not starved and the host is not granted twice in a row while scrub is pending.
- Force 2^CNT_W+3 corrections -> err_count holds at all-ones. err_clr together with an increment -> err_count=0.
- Assert rst_n low during S_WB -> mem_en, mem_we, busy and err_count go to 0 immediately. After release: FSM in IDLE, scrub_ptr=0, no spurious host_ack.

Source files
------------

// File: rtl/ecc_scrub_ctrl_if.sv
// ecc_scrub_ctrl_if: host access port and codeword memory port of the ECC scrub controller
interface ecc_scrub_ctrl_if #(parameter int ADDR_W = 4);
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [3:0]        host_wdata;
    logic              host_ack;
    logic [3:0]        host_rdata;
    logic              host_err;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [6:0]        mem_wdata;
    logic [6:0]        mem_rdata;
    modport slave (
        input  host_req, host_we, host_addr, host_wdata, mem_rdata,
        output host_ack, host_rdata, host_err, mem_en, mem_we, mem_addr, mem_wdata
    );
    modport master (
        output host_req, host_we, host_addr, host_wdata, mem_rdata,
        input  host_ack, host_rdata, host_err, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/ecc_scrub_ctrl.sv
// ecc_scrub_ctrl: Hamming(7,4) host port plus background scrubber sharing one single-port memory.
// Define ECC_HOST_WRITEBACK_EN to write corrected codewords back on erroneous host reads.
module ecc_scrub_ctrl #(
    parameter int ADDR_W         = 4,
    parameter int SCRUB_INTERVAL = 256,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scrub_en,
    input  logic             err_clr,
    ecc_scrub_ctrl_if.slave  bus,
    output logic [CNT_W-1:0] err_count,
    output logic             busy
);
    localparam int TW = (SCRUB_INTERVAL > 2) ? $clog2(SCRUB_INTERVAL) : 1;

    typedef enum logic [2:0] {
        IDLE, H_WR, H_RD, H_RDCHK, S_RD, S_CHK, S_WB
`ifdef ECC_HOST_WRITEBACK_EN
        , H_WB
`endif
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [TW-1:0]     r_tmr;
    logic              r_pend;
    logic              r_last_scrub;

    logic [2:0] w_syn;
    logic [6:0] w_fix;
    logic       w_err;
    logic       w_host;
    logic       w_gnt_s;
    logic       w_wrap;
    logic       w_inc;
    logic [6:0] w_enc;

    assign w_syn   = {bus.mem_rdata[3] ^ bus.mem_rdata[4] ^ bus.mem_rdata[5] ^ bus.mem_rdata[6],
                      bus.mem_rdata[1] ^ bus.mem_rdata[2] ^ bus.mem_rdata[5] ^ bus.mem_rdata[6],
                      bus.mem_rdata[0] ^ bus.mem_rdata[2] ^ bus.mem_rdata[4] ^ bus.mem_rdata[6]};
    assign w_err   = |w_syn;
    assign w_fix   = w_err ? bus.mem_rdata ^ (7'd1 << (w_syn - 3'd1)) : bus.mem_rdata;
    assign w_enc   = {bus.host_wdata[3], bus.host_wdata[2], bus.host_wdata[1],
                      bus.host_wdata[3] ^ bus.host_wdata[2] ^ bus.host_wdata[1],
                      bus.host_wdata[0],
                      bus.host_wdata[3] ^ bus.host_wdata[2] ^ bus.host_wdata[0],
                      bus.host_wdata[3] ^ bus.host_wdata[1] ^ bus.host_wdata[0]};
    // a request seen during its own ack cycle is the access just completed, not a new one
    assign w_host  = bus.host_req & ~bus.host_ack;
    assign w_gnt_s = r_pend & (~w_host | ~r_last_scrub);
    assign w_wrap  = scrub_en & (r_tmr == TW'(SCRUB_INTERVAL - 1));
    assign w_inc   = (r_state == H_RDCHK && w_err) || r_state == S_WB;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmr     <= '0;
            r_pend    <= 1'b0;
            err_count <= '0;
        end else begin
            r_tmr     <= scrub_en ? (w_wrap ? '0 : r_tmr + 1'b1) : '0;
            r_pend    <= w_wrap | (r_pend & ~(r_state == IDLE && w_gnt_s));
            err_count <= err_clr ? '0 : (w_inc && !(&err_count)) ? err_count + 1'b1 : err_count;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_ptr          <= '0;
            r_last_scrub   <= 1'b1;
            busy           <= 1'b0;
            bus.host_ack   <= 1'b0;
            bus.host_rdata <= '0;
            bus.host_err   <= 1'b0;
            bus.mem_en     <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
        end else begin
            bus.host_ack <= 1'b0;
            bus.mem_en   <= 1'b0;
            bus.mem_we   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_gnt_s) begin
                        r_state      <= S_RD;
                        r_last_scrub <= 1'b1;
                        busy         <= 1'b1;
                        bus.mem_en   <= 1'b1;
                        bus.mem_addr <= r_ptr;
                    end else if (w_host) begin
                        r_state       <= bus.host_we ? H_WR : H_RD;
                        r_last_scrub  <= 1'b0;
                        busy          <= 1'b1;
                        bus.mem_en    <= 1'b1;
                        bus.mem_we    <= bus.host_we;
                        bus.mem_addr  <= bus.host_addr;
                        bus.mem_wdata <= w_enc;
                        bus.host_ack  <= bus.host_we;
                    end
                end
                H_RD: r_state <= H_RDCHK;
                H_RDCHK: begin
                    bus.host_ack   <= 1'b1;
                    bus.host_rdata <= {w_fix[6:4], w_fix[2]};
                    bus.host_err   <= w_err;
`ifdef ECC_HOST_WRITEBACK_EN
                    r_state       <= w_err ? H_WB : IDLE;
                    busy          <= w_err;
                    bus.mem_en    <= w_err;
                    bus.mem_we    <= w_err;
                    bus.mem_wdata <= w_fix;
`else
                    r_state <= IDLE;
                    busy    <= 1'b0;
`endif
                end
                S_RD: r_state <= S_CHK;
                S_CHK: begin
                    r_state       <= w_err ? S_WB : IDLE;
                    busy          <= w_err;
                    bus.mem_en    <= w_err;
                    bus.mem_we    <= w_err;
                    bus.mem_wdata <= w_fix;
                    r_ptr         <= w_err ? r_ptr : r_ptr + 1'b1;
                end
                S_WB: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    r_ptr   <= r_ptr + 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// tb_ecc_scrub_ctrl: directed table-driven bench for ecc_scrub_ctrl with a behavioural RAM model
module tb_ecc_scrub_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scrub_en = 1'b0;
    logic       err_clr = 1'b0;
    logic [3:0] err_count;
    logic       busy;
    logic       fill_en = 1'b0;
    logic [6:0] fill_val = '0;
    logic       inj_en = 1'b0;
    logic [3:0] inj_addr = '0;
    logic [6:0] inj_val = '0;
    logic [6:0] mem [16];
    int         pass = 0;
    int         total = 0;

    ecc_scrub_ctrl_if #(.ADDR_W(4)) bus ();

    ecc_scrub_ctrl #(.ADDR_W(4), .SCRUB_INTERVAL(8), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .scrub_en(scrub_en), .err_clr(err_clr),
        .bus(bus), .err_count(err_count), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fill_en) for (int i = 0; i < 16; i++) mem[i] <= fill_val;
        else if (inj_en) mem[inj_addr] <= inj_val;
        if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= mem[bus.mem_addr];
    end

    typedef struct {
        logic       we;
        logic [3:0] addr;
        logic [3:0] d;
        logic [6:0] cw;
        logic [6:0] flip;
        logic [3:0] rd;
        logic       err;
    } vec_t;

    vec_t tv [13];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic host_op(input logic we, input logic [3:0] a, input logic [3:0] d,
                           input logic inj, input logic [6:0] iv, output int lat,
                           output logic [3:0] rd, output logic er,
                           output logic [3:0] wa, output logic [6:0] wcw);
        lat = 0; rd = '0; er = 1'b0; wa = '0; wcw = '0;
        @(negedge clk);
        bus.host_req = 1'b1; bus.host_we = we; bus.host_addr = a; bus.host_wdata = d;
        inj_en = inj; inj_addr = a; inj_val = iv;
        for (int n = 1; n <= 10 && lat == 0; n++) begin
            @(negedge clk);
            inj_en = 1'b0;
            if (bus.mem_en && bus.mem_we) begin wa = bus.mem_addr; wcw = bus.mem_wdata; end
            if (bus.host_ack) begin
                lat = n; rd = bus.host_rdata; er = bus.host_err; bus.host_req = 1'b0;
            end
        end
        bus.host_req = 1'b0;
    endtask

    task automatic get_ev(output logic we, output logic [3:0] a, output logic [6:0] wd);
        bit ok = 0;
        we = 1'b0; a = '0; wd = '0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (bus.mem_en) begin ok = 1; we = bus.mem_we; a = bus.mem_addr; wd = bus.mem_wdata; end
        end
        chk("mem_event_seen", int'(ok), 1);
    endtask

    task automatic fill(input logic [6:0] v);
        @(negedge clk); fill_en = 1'b1; fill_val = v;
        @(negedge clk); fill_en = 1'b0;
    endtask

    initial begin
        int         lat;
        int         exp_cnt;
        logic [3:0] rd, wa, ea;
        logic [6:0] wcw, ewd;
        logic       er, ewe;
        bit         ack_seen;
        logic [8:0] pat;
        tv[0]  = '{1'b1, 4'd2,  4'b1011, 7'b1010101, 7'b0000000, 4'b0000, 1'b0};
        tv[1]  = '{1'b0, 4'd2,  4'b0000, 7'b1010101, 7'b0000000, 4'b1011, 1'b0};
        tv[2]  = '{1'b0, 4'd2,  4'b0000, 7'b1010101, 7'b0010000, 4'b1011, 1'b1};
        tv[3]  = '{1'b1, 4'd5,  4'b0110, 7'b0110011, 7'b0000000, 4'b0000, 1'b0};
        tv[4]  = '{1'b0, 4'd5,  4'b0000, 7'b0110011, 7'b1000000, 4'b0110, 1'b1};
        tv[5]  = '{1'b1, 4'd15, 4'b1111, 7'b1111111, 7'b0000000, 4'b0000, 1'b0};
        tv[6]  = '{1'b0, 4'd15, 4'b0000, 7'b1111111, 7'b0000001, 4'b1111, 1'b1};
        tv[7]  = '{1'b1, 4'd0,  4'b0001, 7'b0000111, 7'b0000000, 4'b0000, 1'b0};
        tv[8]  = '{1'b0, 4'd0,  4'b0000, 7'b0000111, 7'b0000000, 4'b0001, 1'b0};
        tv[9]  = '{1'b1, 4'd9,  4'b1000, 7'b1001011, 7'b0000000, 4'b0000, 1'b0};
        tv[10] = '{1'b0, 4'd9,  4'b0000, 7'b1001011, 7'b0000100, 4'b1000, 1'b1};
        tv[11] = '{1'b1, 4'd3,  4'b0000, 7'b0000000, 7'b0000000, 4'b0000, 1'b0};
        tv[12] = '{1'b0, 4'd3,  4'b0000, 7'b0000000, 7'b0001000, 4'b0000, 1'b1};
        bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
        fill_en = 1'b1;
        repeat (3) @(negedge clk);
        fill_en = 1'b0;
        chk("rst_mem_en", int'(bus.mem_en), 0);
        chk("rst_host_ack", int'(bus.host_ack), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err_count", int'(err_count), 0);
        chk("rst_host_rdata", int'(bus.host_rdata), 0);
        rst_n = 1'b1;

        exp_cnt = 0;
        for (int i = 0; i < 13; i++) begin
            host_op(tv[i].we, tv[i].addr, tv[i].d, tv[i].flip != 0, tv[i].cw ^ tv[i].flip,
                    lat, rd, er, wa, wcw);
            if (tv[i].we) begin
                chk($sformatf("wr_latency[%0d]", i), lat, 1);
                chk($sformatf("wr_addr[%0d]", i), int'(wa), int'(tv[i].addr));
                chk($sformatf("wr_codeword[%0d]", i), int'(wcw), int'(tv[i].cw));
            end else begin
                exp_cnt += int'(tv[i].err);
                chk($sformatf("rd_latency[%0d]", i), lat, 3);
                chk($sformatf("rd_data[%0d]", i), int'(rd), int'(tv[i].rd));
                chk($sformatf("rd_err[%0d]", i), int'(er), int'(tv[i].err));
                chk($sformatf("rd_err_count[%0d]", i), int'(err_count), exp_cnt);
            end
        end

        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        chk("err_clr", int'(err_count), 0);
        fill(7'b0000000);
        @(negedge clk); inj_en = 1'b1; inj_addr = 4'd0; inj_val = 7'b0000001;
        @(negedge clk); inj_en = 1'b0; scrub_en = 1'b1;
        get_ev(ewe, ea, ewd);
        chk("scrub0_rd_we", int'(ewe), 0);
        chk("scrub0_rd_addr", int'(ea), 0);
        get_ev(ewe, ea, ewd);
        chk("scrub0_wb_we", int'(ewe), 1);
        chk("scrub0_wb_addr", int'(ea), 0);
        chk("scrub0_wb_data", int'(ewd), 0);
        @(negedge clk);
        chk("scrub0_err_count", int'(err_count), 1);
        get_ev(ewe, ea, ewd);
        chk("scrub1_rd_we", int'(ewe), 0);
        chk("scrub1_rd_addr", int'(ea), 1);
        get_ev(ewe, ea, ewd);
        chk("scrub2_rd_we", int'(ewe), 0);
        chk("scrub2_rd_addr", int'(ea), 2);
        scrub_en = 1'b0;
        repeat (20) @(negedge clk);

        for (int i = 1; i <= 19; i++) begin
            host_op(1'b0, 4'd1, 4'd0, 1'b1, 7'b0000001, lat, rd, er, wa, wcw);
            chk($sformatf("sat_count[%0d]", i), int'(err_count), (i > 14) ? 15 : i + 1);
        end
        err_clr = 1'b1;
        host_op(1'b0, 4'd1, 4'd0, 1'b1, 7'b0000001, lat, rd, er, wa, wcw);
        err_clr = 1'b0;
        chk("clr_over_inc_err", int'(er), 1);
        chk("clr_over_inc_count", int'(err_count), 0);

        fill(7'b0000000);
        repeat (2) @(negedge clk);
        bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 4'd7; bus.host_wdata = 4'b0101;
        scrub_en = 1'b1;
        pat = 9'b100010000;
        for (int i = 0; i < 9; i++) begin
            get_ev(ewe, ea, ewd);
            chk($sformatf("arb_grant_is_scrub[%0d]", i), int'(!ewe), int'(pat[i]));
        end
        bus.host_req = 1'b0; scrub_en = 1'b0;
        repeat (20) @(negedge clk);

        host_op(1'b0, 4'd1, 4'd0, 1'b1, 7'b0000001, lat, rd, er, wa, wcw);
        chk("pre_rst_err_count", int'(err_count), 1);
        fill(7'b0000001);
        scrub_en = 1'b1;
        ewe = 1'b0;
        for (int i = 0; i < 2 && !ewe; i++) get_ev(ewe, ea, ewd);
        chk("pre_rst_in_swb", int'(ewe && busy), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_mem_en", int'(bus.mem_en), 0);
        chk("rst_async_mem_we", int'(bus.mem_we), 0);
        chk("rst_async_busy", int'(busy), 0);
        chk("rst_async_err_count", int'(err_count), 0);
        scrub_en = 1'b0;
        fill(7'b0000000);
        @(negedge clk); rst_n = 1'b1;
        ack_seen = 0;
        repeat (6) begin @(negedge clk); if (bus.host_ack) ack_seen = 1; end
        chk("no_spurious_ack", int'(ack_seen), 0);
        chk("post_rst_idle", int'(busy), 0);
        scrub_en = 1'b1;
        repeat (8) @(negedge clk);
        bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 4'd7; bus.host_wdata = 4'b0011;
        get_ev(ewe, ea, ewd);
        chk("first_tie_host_we", int'(ewe), 1);
        chk("first_tie_host_addr", int'(ea), 7);
        get_ev(ewe, ea, ewd);
        chk("first_tie_then_scrub_we", int'(ewe), 0);
        chk("post_rst_scrub_ptr", int'(ea), 0);
        bus.host_req = 1'b0; scrub_en = 1'b0;
        repeat (10) @(negedge clk);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
